// File: rtl/aes_inv_keyschedule_if.sv
// Handshake and data bundle between the key store / inverse cipher and the
// decrypt-side AES-128 key schedule.
interface aes_inv_keyschedule_if;
    logic                 start;
    logic [127:0]         last_key;
    logic [255:0][7:0]    SBOX;
    logic                 rk_ready;
    logic                 rk_valid;
    logic [127:0]         rk;
    logic [3:0]           rk_round;
    logic                 busy;
    logic                 done;

    // Requester side: issues start/key, supplies the S-box, consumes round keys.
    modport master (
        output start, last_key, SBOX, rk_ready,
        input  rk_valid, rk, rk_round, busy, done
    );

    // Key schedule side.
    modport slave (
        input  start, last_key, SBOX, rk_ready,
        output rk_valid, rk, rk_round, busy, done
    );
endinterface

// File: rtl/aes_inv_keyschedule.sv
// Decrypt-side AES-128 key schedule. Starting from the round-NR key it walks
// the forward expansion backwards and hands out round keys NR..0, one per
// rk_valid/rk_ready handshake, with one recompute cycle between keys.
module aes_inv_keyschedule #(
    parameter int         NR        = 10,
    parameter logic [7:0] RCON_LAST = 8'h36
) (
    input  logic                  eph1,
    input  logic                  reset,
    aes_inv_keyschedule_if.slave  bus
);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] EMIT = 2'd1;
    localparam logic [1:0] CALC = 2'd2;

    localparam logic [3:0] ROUND_LAST = 4'(NR);

    logic [1:0]   state_q, state_d;
    logic [127:0] rk_q, rk_d;
    logic [3:0]   round_q, round_d;
    logic [7:0]   rcon_q, rcon_d;
    logic         busy_q, busy_d;
    logic         done_q, done_d;

    // Inverse of xtime: steps the round constant one round backwards.
    function automatic logic [7:0] next_rcon(input logic [7:0] x);
        return x[0] ? (((x ^ 8'h1b) >> 1) | 8'h80) : (x >> 1);
    endfunction

    // SubWord(RotWord(w)); the S-box stores byte x at index 255-x, i.e. ~x.
    function automatic logic [31:0] sub_rot_word(input logic [255:0][7:0] sbox,
                                                 input logic [31:0]        w);
        return {sbox[~w[23:16]], sbox[~w[15:8]], sbox[~w[7:0]], sbox[~w[31:24]]};
    endfunction

    // One backward step of the key expansion: round r key -> round r-1 key.
    // p3 must be formed first because the word-0 recovery depends on it.
    function automatic logic [127:0] prev_key(input logic [255:0][7:0] sbox,
                                              input logic [127:0]       k,
                                              input logic [7:0]         rcon);
        logic [31:0] p0, p1, p2, p3;
        p3 = k[31:0]   ^ k[63:32];
        p2 = k[63:32]  ^ k[95:64];
        p1 = k[95:64]  ^ k[127:96];
        p0 = k[127:96] ^ sub_rot_word(sbox, p3) ^ {rcon, 24'h0};
        return {p0, p1, p2, p3};
    endfunction

    // Next-state logic for the IDLE -> EMIT -> (CALC -> EMIT)* -> IDLE walk.
    always_comb begin
        state_d = state_q;
        rk_d    = rk_q;
        round_d = round_q;
        rcon_d  = rcon_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                // A start coinciding with the done pulse is dropped; the
                // requester must re-issue it on the following cycle.
                if (bus.start && !done_q) begin
                    rk_d    = bus.last_key;
                    round_d = ROUND_LAST;
                    rcon_d  = RCON_LAST;
                    busy_d  = 1'b1;
                    state_d = EMIT;
                end
            end
            EMIT: begin
                if (bus.rk_ready) begin
                    if (round_q != 4'd0) begin
                        state_d = CALC;
                    end else begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                        busy_d  = 1'b0;
                    end
                end
            end
            CALC: begin
                rk_d    = prev_key(bus.SBOX, rk_q, rcon_q);
                round_d = round_q - 4'd1;
                rcon_d  = next_rcon(rcon_q);
                state_d = EMIT;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State registers; reset clears everything, including the key register.
    always_ff @(posedge eph1) begin
        if (reset) begin
            state_q <= IDLE;
            rk_q    <= 128'h0;
            round_q <= 4'd0;
            rcon_q  <= RCON_LAST;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            rk_q    <= rk_d;
            round_q <= round_d;
            rcon_q  <= rcon_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign bus.rk_valid = (state_q == EMIT);
    assign bus.rk       = rk_q;
    assign bus.rk_round = round_q;
    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
endmodule

// File: tb/tb_aes_inv_keyschedule.sv
// Bench for the decrypt-side AES-128 key schedule: builds the S-box from GF(2^8)
// arithmetic, models the forward and backward expansion at word level and
// compares every emitted round key against it.
module tb_aes_inv_keyschedule;
    logic eph1 = 1'b0;
    logic reset;

    aes_inv_keyschedule_if bus();

    aes_inv_keyschedule dut (
        .eph1  (eph1),
        .reset (reset),
        .bus   (bus)
    );

    always #5 eph1 = ~eph1;

    localparam logic [127:0] FIPS_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] FIPS_R10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    localparam logic [127:0] FIPS_R9  = 128'hac7766f319fadc2128d12941575c006e;
    localparam logic [127:0] FIPS_R1  = 128'ha0fafe1788542cb123a339392a6c7605;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0]   sbox_m [256];
    logic [7:0]   rcon_m [10];
    logic [127:0] exp_fwd [11];
    logic [127:0] exp_inv [11];

    logic [127:0] got_rk [11];
    int           got_n, got_order, got_unstable, got_first, got_done_cyc;
    bit           got_timeout;

    // ---------------- reference model ----------------
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x, y;
        p = 8'h00; x = a; y = b;
        for (int i = 0; i < 8; i++) begin
            if (y[0]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
            y = y >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
        return 8'((b << n) | (b >> (8 - n)));
    endfunction

    task automatic build_tables();
        logic [7:0] inv;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++)
                if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            sbox_m[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
        end
        rcon_m[0] = 8'h01;
        for (int i = 1; i < 10; i++)
            rcon_m[i] = {rcon_m[i-1][6:0], 1'b0} ^ (rcon_m[i-1][7] ? 8'h1b : 8'h00);
    endtask

    function automatic logic [31:0] m_subrot(input logic [31:0] t);
        return {sbox_m[t[23:16]], sbox_m[t[15:8]], sbox_m[t[7:0]], sbox_m[t[31:24]]};
    endfunction

    // Forward expansion: exp_fwd[r] is round key r of cipher key 'key'.
    task automatic fwd_expand(input logic [127:0] key);
        logic [31:0] w [44];
        logic [31:0] t;
        for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) t = m_subrot(t) ^ {rcon_m[i/4-1], 24'h0};
            w[i] = w[i-4] ^ t;
        end
        for (int r = 0; r < 11; r++) exp_fwd[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endtask

    // Backward expansion solved word by word: w[i-4] = w[i] ^ f(w[i-1]).
    task automatic inv_expand(input logic [127:0] last);
        logic [31:0] w [44];
        logic [31:0] t;
        for (int i = 0; i < 4; i++) w[40+i] = last[127-32*i -: 32];
        for (int i = 43; i >= 4; i--) begin
            t = w[i-1];
            if (i % 4 == 0) t = m_subrot(t) ^ {rcon_m[i/4-1], 24'h0};
            w[i-4] = w[i] ^ t;
        end
        for (int r = 0; r < 11; r++) exp_inv[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endtask

    // ---------------- stimulus driver ----------------
    // Issues one start, consumes keys with rk_ready at ready_pct percent and
    // records them; returns one cycle after the done pulse.
    task automatic run_seq(input logic [127:0] key, input int ready_pct);
        bit           stalled, seen_done;
        logic [127:0] held_rk;
        logic [3:0]   held_round;
        int           cyc;
        got_n = 0; got_order = 0; got_unstable = 0; got_first = -1;
        got_done_cyc = -1; got_timeout = 0;
        stalled = 0; seen_done = 0; cyc = 0;
        held_rk = '0; held_round = '0;
        bus.last_key = key;
        bus.start    = 1'b1;
        @(posedge eph1); #1;
        bus.start    = 1'b0;
        bus.last_key = ~key;
        while (!seen_done) begin
            bus.rk_ready = ($urandom_range(99) < ready_pct);
            if (bus.rk_valid === 1'b1) begin
                if (got_first < 0) got_first = cyc;
                if (stalled && (bus.rk !== held_rk || bus.rk_round !== held_round))
                    got_unstable++;
                if (bus.rk_ready) begin
                    if (got_n < 11) begin
                        got_rk[got_n] = bus.rk;
                        if (bus.rk_round !== 4'(10 - got_n)) got_order++;
                    end
                    got_n++;
                    stalled = 0;
                end else begin
                    stalled    = 1;
                    held_rk    = bus.rk;
                    held_round = bus.rk_round;
                end
            end
            @(posedge eph1); #1;
            cyc++;
            if (bus.done === 1'b1) begin
                seen_done    = 1;
                got_done_cyc = cyc;
            end else if (cyc > 400) begin
                got_timeout = 1;
                seen_done   = 1;
            end
        end
        bus.rk_ready = 1'b0;
        @(posedge eph1); #1;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        reset = 1'b1;
        bus.start = 1'b0; bus.rk_ready = 1'b0; bus.last_key = 128'h0;
        repeat (3) @(posedge eph1);
        #1;
        n_checks++; if (bus.rk_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rk_valid got=%b want=0", bus.rk_valid); end
        n_checks++; if (bus.rk !== 128'h0) begin n_fail++; $display("FAIL reset_rk got=%h want=0", bus.rk); end
        n_checks++; if (bus.rk_round !== 4'd0) begin n_fail++; $display("FAIL reset_rk_round got=%0d want=0", bus.rk_round); end
        n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%b want=0", bus.busy); end
        n_checks++; if (bus.done !== 1'b0) begin n_fail++; $display("FAIL reset_done got=%b want=0", bus.done); end
        reset = 1'b0;
        @(posedge eph1); #1;
    endtask

    task automatic test_fips();
        fwd_expand(FIPS_KEY);
        run_seq(FIPS_R10, 100);
        n_checks++; if (got_timeout) begin n_fail++; $display("FAIL fips_timeout got=1 want=0"); end
        n_checks++; if (got_n !== 11) begin n_fail++; $display("FAIL fips_count got=%0d want=11", got_n); end
        n_checks++; if (got_order !== 0) begin n_fail++; $display("FAIL fips_round_order errors=%0d want=0", got_order); end
        n_checks++; if (got_first !== 0) begin n_fail++; $display("FAIL fips_start_latency got=%0d want=0", got_first); end
        n_checks++; if (got_done_cyc - got_first !== 21) begin n_fail++; $display("FAIL fips_done_latency got=%0d want=21", got_done_cyc - got_first); end
        for (int i = 0; i < 11; i++) begin
            n_checks++;
            if (got_rk[i] !== exp_fwd[10-i]) begin n_fail++; $display("FAIL fips_rk round=%0d got=%h want=%h", 10-i, got_rk[i], exp_fwd[10-i]); end
        end
        n_checks++; if (got_rk[1] !== FIPS_R9) begin n_fail++; $display("FAIL fips_r9_const got=%h want=%h", got_rk[1], FIPS_R9); end
        n_checks++; if (got_rk[9] !== FIPS_R1) begin n_fail++; $display("FAIL fips_r1_const got=%h want=%h", got_rk[9], FIPS_R1); end
        n_checks++; if (got_rk[10] !== FIPS_KEY) begin n_fail++; $display("FAIL fips_r0_const got=%h want=%h", got_rk[10], FIPS_KEY); end
        n_checks++; if (bus.rk !== FIPS_KEY) begin n_fail++; $display("FAIL idle_rk_hold got=%h want=%h", bus.rk, FIPS_KEY); end
        n_checks++; if (bus.rk_valid !== 1'b0) begin n_fail++; $display("FAIL idle_rk_valid got=%b want=0", bus.rk_valid); end
        n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL idle_busy got=%b want=0", bus.busy); end
    endtask

    task automatic test_backpressure();
        inv_expand(FIPS_R10);
        for (int k = 0; k < 4; k++) begin
            run_seq(FIPS_R10, 30);
            n_checks++; if (got_timeout) begin n_fail++; $display("FAIL bp_timeout run=%0d", k); end
            n_checks++; if (got_n !== 11) begin n_fail++; $display("FAIL bp_count run=%0d got=%0d want=11", k, got_n); end
            n_checks++; if (got_order !== 0) begin n_fail++; $display("FAIL bp_round_order run=%0d errors=%0d want=0", k, got_order); end
            n_checks++; if (got_unstable !== 0) begin n_fail++; $display("FAIL bp_stable run=%0d changes=%0d want=0", k, got_unstable); end
            for (int i = 0; i < 11; i++) begin
                n_checks++;
                if (got_rk[i] !== exp_inv[10-i]) begin n_fail++; $display("FAIL bp_rk run=%0d round=%0d got=%h want=%h", k, 10-i, got_rk[i], exp_inv[10-i]); end
            end
        end
    endtask

    task automatic test_roundtrip();
        logic [127:0] key;
        for (int k = 0; k < 1000; k++) begin
            key = {$urandom, $urandom, $urandom, $urandom};
            fwd_expand(key);
            run_seq(exp_fwd[10], 100);
            n_checks++;
            if (got_n !== 11 || got_timeout) begin n_fail++; $display("FAIL rt_count key=%h got=%0d want=11", key, got_n); end
            for (int i = 0; i < 11; i++) begin
                n_checks++;
                if (got_rk[i] !== exp_fwd[10-i]) begin n_fail++; $display("FAIL rt_rk key=%h round=%0d got=%h want=%h", key, 10-i, got_rk[i], exp_fwd[10-i]); end
            end
        end
    endtask

    task automatic test_start_ignored();
        logic [127:0] key2;
        int cyc, n;
        bit done_seen, injected;
        key2 = {$urandom, $urandom, $urandom, $urandom};
        fwd_expand(FIPS_KEY);
        bus.last_key = FIPS_R10; bus.start = 1'b1; bus.rk_ready = 1'b1;
        @(posedge eph1); #1;
        bus.start = 1'b0;
        cyc = 0; n = 0; done_seen = 0; injected = 0;
        while (!done_seen && cyc < 100) begin
            if (bus.rk_valid === 1'b1) begin
                if (n < 11) got_rk[n] = bus.rk;
                n++;
                if (bus.rk_round === 4'd6 && !injected) begin
                    bus.start = 1'b1; bus.last_key = key2; injected = 1;
                end
            end
            @(posedge eph1); #1;
            bus.start = 1'b0;
            cyc++;
            if (bus.done === 1'b1) done_seen = 1;
        end
        n_checks++; if (!done_seen) begin n_fail++; $display("FAIL busy_start_timeout got=0 want=done"); end
        n_checks++; if (n !== 11) begin n_fail++; $display("FAIL busy_start_count got=%0d want=11", n); end
        for (int i = 0; i < 11; i++) begin
            n_checks++;
            if (got_rk[i] !== exp_fwd[10-i]) begin n_fail++; $display("FAIL busy_start_rk round=%0d got=%h want=%h", 10-i, got_rk[i], exp_fwd[10-i]); end
        end
        // start on the done cycle, then held into the following cycle
        bus.start = 1'b1; bus.last_key = key2;
        @(posedge eph1); #1;
        n_checks++; if (bus.rk_valid !== 1'b0) begin n_fail++; $display("FAIL done_start_ignored rk_valid got=%b want=0", bus.rk_valid); end
        n_checks++; if (bus.rk !== FIPS_KEY) begin n_fail++; $display("FAIL done_start_rk got=%h want=%h", bus.rk, FIPS_KEY); end
        @(posedge eph1); #1;
        bus.start = 1'b0;
        n_checks++; if (bus.rk_valid !== 1'b1) begin n_fail++; $display("FAIL restart_rk_valid got=%b want=1", bus.rk_valid); end
        n_checks++; if (bus.rk_round !== 4'd10) begin n_fail++; $display("FAIL restart_round got=%0d want=10", bus.rk_round); end
        n_checks++; if (bus.rk !== key2) begin n_fail++; $display("FAIL restart_rk got=%h want=%h", bus.rk, key2); end
        n_checks++; if (bus.busy !== 1'b1) begin n_fail++; $display("FAIL restart_busy got=%b want=1", bus.busy); end
        cyc = 0; done_seen = 0;
        while (!done_seen && cyc < 100) begin
            @(posedge eph1); #1;
            cyc++;
            if (bus.done === 1'b1) done_seen = 1;
        end
        n_checks++; if (!done_seen) begin n_fail++; $display("FAIL restart_drain_timeout got=0 want=done"); end
        bus.rk_ready = 1'b0;
        @(posedge eph1); #1;
    endtask

    task automatic test_reset_mid();
        int cyc, dones;
        bit hit;
        fwd_expand(FIPS_KEY);
        bus.last_key = FIPS_R10; bus.start = 1'b1; bus.rk_ready = 1'b1;
        @(posedge eph1); #1;
        bus.start = 1'b0;
        cyc = 0; hit = 0;
        while (!hit && cyc < 100) begin
            if (bus.rk_valid === 1'b1 && bus.rk_round === 4'd4) hit = 1;
            @(posedge eph1); #1;
            cyc++;
        end
        n_checks++; if (!hit) begin n_fail++; $display("FAIL rmid_reach_round4 got=0 want=1"); end
        n_checks++; if (bus.rk_valid !== 1'b0) begin n_fail++; $display("FAIL rmid_in_calc rk_valid got=%b want=0", bus.rk_valid); end
        reset = 1'b1;
        @(posedge eph1); #1;
        reset = 1'b0;
        n_checks++; if (bus.rk_valid !== 1'b0) begin n_fail++; $display("FAIL rmid_rk_valid got=%b want=0", bus.rk_valid); end
        n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL rmid_busy got=%b want=0", bus.busy); end
        n_checks++; if (bus.rk !== 128'h0) begin n_fail++; $display("FAIL rmid_rk got=%h want=0", bus.rk); end
        n_checks++; if (bus.rk_round !== 4'd0) begin n_fail++; $display("FAIL rmid_rk_round got=%0d want=0", bus.rk_round); end
        dones = 0;
        for (int i = 0; i < 6; i++) begin
            if (bus.done !== 1'b0 || bus.rk_valid !== 1'b0) dones++;
            @(posedge eph1); #1;
        end
        n_checks++; if (dones !== 0) begin n_fail++; $display("FAIL rmid_quiet activity=%0d want=0", dones); end
        bus.rk_ready = 1'b0;
        run_seq(FIPS_R10, 100);
        n_checks++; if (got_n !== 11 || got_timeout) begin n_fail++; $display("FAIL rmid_rerun_count got=%0d want=11", got_n); end
        for (int i = 0; i < 11; i++) begin
            n_checks++;
            if (got_rk[i] !== exp_fwd[10-i]) begin n_fail++; $display("FAIL rmid_rerun_rk round=%0d got=%h want=%h", 10-i, got_rk[i], exp_fwd[10-i]); end
        end
    endtask

    task automatic test_zero_key();
        inv_expand(128'h0);
        run_seq(128'h0, 100);
        n_checks++; if (got_n !== 11 || got_timeout) begin n_fail++; $display("FAIL zero_count got=%0d want=11", got_n); end
        for (int i = 0; i < 11; i++) begin
            n_checks++;
            if (got_rk[i] !== exp_inv[10-i]) begin n_fail++; $display("FAIL zero_rk round=%0d got=%h want=%h", 10-i, got_rk[i], exp_inv[10-i]); end
        end
        fwd_expand(got_rk[10]);
        n_checks++; if (exp_fwd[10] !== 128'h0) begin n_fail++; $display("FAIL zero_forward_consistent got=%h want=0", exp_fwd[10]); end
    endtask

    initial begin
        #3000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        bus.start = 1'b0;
        bus.rk_ready = 1'b0;
        bus.last_key = 128'h0;
        build_tables();
        for (int x = 0; x < 256; x++) bus.SBOX[255-x] = sbox_m[x];
        test_reset();
        test_fips();
        test_backpressure();
        test_start_ignored();
        test_reset_mid();
        test_zero_key();
        test_roundtrip();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
